// File: rtl/char_move_ctrl.sv
// Tile-based character movement controller: turns, 16-px walk/run steps and
// forced spin-tile slides, all paced by the per-frame tick.
module char_move_ctrl (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       frame_tick,
  input  logic [7:0] keycode,
  input  logic       run_held,
  input  logic [3:0] state_num,
  input  logic       blocked,
  input  logic       atTile,
  input  logic [1:0] spin_direction,
  output logic [9:0] charxcurrpos,
  output logic [9:0] charycurrpos,
  output logic [1:0] direction,
  output logic       charIsMoving,
  output logic       charIsRunning,
  output logic [1:0] charMoveFrame,
  output logic       step_done
);

  // state | meaning
  // IDLE  | on a tile boundary, waiting for a key
  // TURN  | facing changed, 4-tick pause before a step may start
  // WALK  | key-driven 16-px step, 1 or 2 px per tick
  // SPIN  | forced 16-px slide at 2 px per tick while on spin tiles
  typedef enum logic [1:0] {IDLE, TURN, WALK, SPIN} state_t;

  localparam logic [1:0] DIR_DOWN  = 2'd0;
  localparam logic [1:0] DIR_UP    = 2'd1;
  localparam logic [1:0] DIR_LEFT  = 2'd2;
  localparam logic [1:0] DIR_RIGHT = 2'd3;

  state_t      state_q, state_d;
  logic [1:0]  dir_q, dir_d;
  logic [9:0]  x_q, x_d;
  logic [9:0]  y_q, y_d;
  logic [4:0]  pix_q, pix_d;
  logic [1:0]  turn_cnt_q, turn_cnt_d;
  logic        running_q, running_d;
  logic        done_q, done_d;

  logic        key_valid;
  logic [1:0]  key_dir;
  logic        at_bound;
  logic [4:0]  step_px;
  logic [4:0]  pix_moved;
  logic [9:0]  delta;

  always_comb begin
    key_valid = 1'b1;
    key_dir   = DIR_DOWN;
    case (keycode)
      8'h1A:   key_dir = DIR_UP;
      8'h16:   key_dir = DIR_DOWN;
      8'h04:   key_dir = DIR_LEFT;
      8'h07:   key_dir = DIR_RIGHT;
      default: key_valid = 1'b0;
    endcase
  end

  // A step starting here would end outside x in [0,624] / y in [0,464].
  always_comb begin
    at_bound = 1'b0;
    case (dir_q)
      DIR_DOWN:  at_bound = (y_q > 10'd448);
      DIR_UP:    at_bound = (y_q < 10'd16);
      DIR_LEFT:  at_bound = (x_q < 10'd16);
      DIR_RIGHT: at_bound = (x_q > 10'd608);
      default:   at_bound = 1'b0;
    endcase
  end

  assign step_px   = ((state_q == SPIN) || running_q) ? 5'd2 : 5'd1;
  assign pix_moved = pix_q + step_px;
  assign delta     = {5'd0, step_px};

  always_comb begin
    state_d    = state_q;
    dir_d      = dir_q;
    x_d        = x_q;
    y_d        = y_q;
    pix_d      = pix_q;
    turn_cnt_d = turn_cnt_q;
    running_d  = running_q;
    done_d     = 1'b0;
    case (state_q)
      IDLE: begin
        pix_d     = 5'd0;
        running_d = 1'b0;
        if (state_num == 4'd3 && key_valid) begin
          if (key_dir != dir_q) begin
            dir_d      = key_dir;
            turn_cnt_d = 2'd3;
            state_d    = TURN;
          end else if (!blocked && !at_bound) begin
            running_d = run_held;
            state_d   = WALK;
          end
        end
      end
      TURN: begin
        if (frame_tick) begin
          if (turn_cnt_q == 2'd0) state_d = IDLE;
          else                    turn_cnt_d = turn_cnt_q - 2'd1;
        end
      end
      WALK, SPIN: begin
        if (frame_tick) begin
          if (state_q == SPIN && pix_q == 5'd0 && (blocked || at_bound)) begin
            state_d = IDLE;
          end else begin
            case (dir_q)
              DIR_DOWN:  y_d = y_q + delta;
              DIR_UP:    y_d = y_q - delta;
              DIR_LEFT:  x_d = x_q - delta;
              default:   x_d = x_q + delta;
            endcase
            if (pix_moved == 5'd16) begin
              done_d    = 1'b1;
              pix_d     = 5'd0;
              running_d = 1'b0;
              if (atTile) begin
                dir_d   = spin_direction;
                state_d = SPIN;
              end else begin
                state_d = IDLE;
              end
            end else begin
              pix_d = pix_moved;
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q    <= IDLE;
      dir_q      <= DIR_DOWN;
      x_q        <= 10'd320;
      y_q        <= 10'd240;
      pix_q      <= 5'd0;
      turn_cnt_q <= 2'd0;
      running_q  <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      dir_q      <= dir_d;
      x_q        <= x_d;
      y_q        <= y_d;
      pix_q      <= pix_d;
      turn_cnt_q <= turn_cnt_d;
      running_q  <= running_d;
      done_q     <= done_d;
    end
  end

  assign charxcurrpos  = x_q;
  assign charycurrpos  = y_q;
  assign direction     = dir_q;
  assign charIsMoving  = (state_q == WALK) || (state_q == SPIN);
  assign charIsRunning = running_q;
  assign charMoveFrame = (state_q == WALK) ? pix_q[3:2] : 2'd0;
  assign step_done     = done_q;

endmodule

// File: tb/tb_char_move_ctrl.sv
// Directed bench for char_move_ctrl: turn, walk, run, spin chaining,
// boundary/state gating and asynchronous reset mid-step.
module tb_char_move_ctrl;

  logic       Clk = 1'b0;
  logic       Reset = 1'b1;
  logic       frame_tick = 1'b0;
  logic [7:0] keycode = 8'h00;
  logic       run_held = 1'b0;
  logic [3:0] state_num = 4'd0;
  logic       blocked = 1'b0;
  logic       atTile = 1'b0;
  logic [1:0] spin_direction = 2'd0;
  logic [9:0] charxcurrpos, charycurrpos;
  logic [1:0] direction;
  logic       charIsMoving, charIsRunning;
  logic [1:0] charMoveFrame;
  logic       step_done;

  int n_chk = 0;
  int n_pass = 0;

  char_move_ctrl dut (
    .Clk(Clk), .Reset(Reset), .frame_tick(frame_tick), .keycode(keycode),
    .run_held(run_held), .state_num(state_num), .blocked(blocked),
    .atTile(atTile), .spin_direction(spin_direction),
    .charxcurrpos(charxcurrpos), .charycurrpos(charycurrpos),
    .direction(direction), .charIsMoving(charIsMoving),
    .charIsRunning(charIsRunning), .charMoveFrame(charMoveFrame),
    .step_done(step_done)
  );

  always #5 Clk = ~Clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  // One-clock frame_tick pulse; returns at the negedge after the ticked edge.
  task automatic tick();
    @(negedge Clk) frame_tick = 1'b1;
    @(negedge Clk) frame_tick = 1'b0;
  endtask

  initial begin
    int xe, ye;
    repeat (2) @(negedge Clk);
    chk("rst_x", charxcurrpos, 320);
    chk("rst_y", charycurrpos, 240);
    Reset = 1'b0;
    @(negedge Clk);
    chk("rst_dir", direction, 0);
    chk("rst_moving", charIsMoving, 0);
    chk("rst_running", charIsRunning, 0);
    chk("rst_frame", charMoveFrame, 0);
    chk("rst_done", step_done, 0);

    // Turn from down to right, then a walk step begins
    state_num = 4'd3;
    keycode   = 8'h07;
    @(negedge Clk);
    chk("turn_dir", direction, 3);
    chk("turn_moving", charIsMoving, 0);
    for (int k = 1; k <= 4; k++) begin
      tick();
      chk("turn_x", charxcurrpos, 320);
      chk("turn_moving_t", charIsMoving, 0);
      chk("turn_frame", charMoveFrame, 0);
    end
    @(negedge Clk);
    chk("walk_start", charIsMoving, 1);
    chk("walk_running", charIsRunning, 0);
    chk("walk_frame0", charMoveFrame, 0);

    // Walk: 16 ticks, 1 px each
    for (int k = 1; k <= 16; k++) begin
      tick();
      if (k == 1) keycode = 8'h00;
      chk("walk_x", charxcurrpos, 320 + k);
      chk("walk_frame", charMoveFrame, (k < 16) ? ((k / 4) % 4) : 0);
      chk("walk_done", step_done, (k == 16) ? 1 : 0);
      chk("walk_moving", charIsMoving, (k < 16) ? 1 : 0);
    end
    @(negedge Clk);
    chk("walk_done_clr", step_done, 0);
    chk("walk_idle_x", charxcurrpos, 336);

    // Run: latched at entry, run_held dropped mid-step
    keycode  = 8'h07;
    run_held = 1'b1;
    @(negedge Clk);
    keycode = 8'h00;
    chk("run_latched", charIsRunning, 1);
    for (int k = 1; k <= 8; k++) begin
      tick();
      if (k == 2) run_held = 1'b0;
      chk("run_x", charxcurrpos, 336 + 2 * k);
      chk("run_running", charIsRunning, (k < 8) ? 1 : 0);
      chk("run_done", step_done, (k == 8) ? 1 : 0);
    end
    chk("run_idle", charIsMoving, 0);

    // Run step ending on a spin tile, spin chained once, then blocked
    keycode        = 8'h07;
    run_held       = 1'b1;
    atTile         = 1'b1;
    spin_direction = 2'd1;
    @(negedge Clk);
    keycode  = 8'h00;
    run_held = 1'b0;
    repeat (8) tick();
    chk("spin_enter_x", charxcurrpos, 368);
    chk("spin_enter_dir", direction, 1);
    chk("spin_enter_moving", charIsMoving, 1);
    chk("spin_enter_done", step_done, 1);
    for (int k = 1; k <= 8; k++) begin
      tick();
      chk("spin_y", charycurrpos, 240 - 2 * k);
      chk("spin_running", charIsRunning, 0);
      chk("spin_frame", charMoveFrame, 0);
      chk("spin_moving", charIsMoving, 1);
    end
    chk("spin_chain_done", step_done, 1);
    blocked = 1'b1;
    tick();
    chk("spin_block_moving", charIsMoving, 0);
    chk("spin_block_y", charycurrpos, 224);
    chk("spin_block_done", step_done, 0);
    blocked = 1'b0;
    atTile  = 1'b0;

    // Turn right and run to the right boundary
    keycode = 8'h07;
    @(negedge Clk);
    chk("bturn_dir", direction, 3);
    repeat (4) tick();
    keycode = 8'h00;
    xe = 368;
    for (int s = 0; s < 16; s++) begin
      keycode  = 8'h07;
      run_held = 1'b1;
      @(negedge Clk);
      keycode  = 8'h00;
      run_held = 1'b0;
      repeat (8) tick();
      xe = xe + 16;
    end
    chk("bound_x", charxcurrpos, xe);
    chk("bound_x624", charxcurrpos, 624);
    keycode = 8'h07;
    repeat (2) @(negedge Clk);
    chk("bound_moving", charIsMoving, 0);
    tick();
    chk("bound_hold_x", charxcurrpos, 624);
    chk("bound_hold_moving", charIsMoving, 0);

    // Keys ignored outside the overworld
    state_num = 4'd0;
    keycode   = 8'h04;
    repeat (2) @(negedge Clk);
    tick();
    chk("sn_dir", direction, 3);
    chk("sn_moving", charIsMoving, 0);

    // Reset asserted mid-step
    state_num = 4'd3;
    @(negedge Clk);
    chk("rs_turn_dir", direction, 2);
    repeat (4) tick();
    @(negedge Clk);
    keycode = 8'h00;
    chk("rs_walk", charIsMoving, 1);
    repeat (5) tick();
    chk("rs_x5", charxcurrpos, 619);
    #1 Reset = 1'b1;
    #1;
    chk("rs_async_x", charxcurrpos, 320);
    ye = 240;
    chk("rs_async_y", charycurrpos, ye);
    chk("rs_async_dir", direction, 0);
    chk("rs_async_moving", charIsMoving, 0);
    chk("rs_async_running", charIsRunning, 0);
    chk("rs_async_frame", charMoveFrame, 0);
    for (int k = 0; k < 3; k++) begin
      @(negedge Clk);
      chk("rs_no_done", step_done, 0);
    end
    Reset = 1'b0;
    repeat (3) @(negedge Clk);
    chk("rs_after_done", step_done, 0);
    chk("rs_after_x", charxcurrpos, 320);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/char_move_ctrl.md
CHAR_MOVE_CTRL -- requirements
Module: char_move_ctrl

Interface
REQ-001 SHALL have port: Clk  input  1  sole system clock; all state changes on rising edge.
REQ-002 SHALL have port: Reset  input  1  asynchronous, active-high; forces every register to its reset value immediately, independent of Clk.
REQ-003 SHALL have port: frame_tick  input  1  one-Clk pulse per video frame; the movement time base.
REQ-004 SHALL have port: keycode  input  8  USB HID code: 0x1A up, 0x16 down, 0x04 left, 0x07 right; any other code = no key.
REQ-005 SHALL have port: run_held  input  1  run modifier held.
REQ-006 SHALL have port: state_num  input  4  game state; overworld = 4'd3.
REQ-007 SHALL have port: blocked  input  1  collision flag for the tile adjacent in the current `direction`; valid combinationally.
REQ-008 SHALL have port: atTile  input  1  character stands on a spin tile; sampled only at step end.
REQ-009 SHALL have port: spin_direction  input  2  forced direction while atTile.
REQ-010 SHALL have port: charxcurrpos, charycurrpos  output  10 each  top-left pixel of the character.
REQ-011 SHALL have port: direction  output  2  facing: 0 down, 1 up, 2 left, 3 right.
REQ-012 SHALL have port: charIsMoving, charIsRunning  output  1 each  step in progress; run speed latched.
REQ-013 SHALL have port: charMoveFrame  output  2  walk-animation frame.
REQ-014 SHALL have port: step_done  output  1  one-Clk pulse on completion of each 16-px step.

Function
REQ-015 SHALL implement FSM states IDLE, TURN, WALK, SPIN; all movement advances only on Clk edges where frame_tick=1.
REQ-016 IDLE: with state_num=3 and a valid key: if key direction differs from `direction`, SHALL load `direction` and enter TURN; otherwise, if not blocked and not at boundary, SHALL enter WALK; otherwise remain IDLE.
REQ-017 TURN SHALL last exactly 4 frame_ticks with no position change, then return to IDLE.
REQ-018 On WALK entry, SHALL latch run_held into charIsRunning and hold it for the whole step.
REQ-019 WALK SHALL move 1 px per frame_tick (walk) or 2 px per frame_tick (run) in `direction`; the step is exactly 16 px (16 or 8 ticks).
REQ-020 Key changes, blocked, and run_held SHALL be ignored during WALK, SPIN, and TURN.
REQ-021 charMoveFrame SHALL increment modulo 4 every 4 px moved (wrapping 3->0) and SHALL be 0 in IDLE and TURN.
REQ-022 On the Clk edge where the 16th px is applied: SHALL pulse step_done for one Clk; if atTile=1, SHALL load `direction` <= spin_direction and enter SPIN; otherwise SHALL enter IDLE.
REQ-023 SPIN SHALL move 2 px per tick in `direction`, with no key required, charIsRunning=0, and charMoveFrame held at 0; step ends per REQ-022 (chains while atTile=1).
REQ-024 Entering or continuing SPIN with blocked=1 or at a boundary SHALL end in IDLE with no movement.
REQ-025 Boundaries: x in [0,624], y in [0,464]; a step that would leave the range SHALL be treated as blocked.
REQ-026 charIsMoving SHALL be 1 exactly in WALK and SPIN.
REQ-027 If state_num leaves 3 mid-step, SHALL finish the current step, then stay in IDLE (no new steps or turns).
REQ-028 Positions SHALL always remain multiples of 16 when in IDLE.

Reset
REQ-029 On Reset: state IDLE; charxcurrpos=320; charycurrpos=240; direction=0; charIsMoving=0; charIsRunning=0; charMoveFrame=0; step_done=0.
REQ-030 Reset asserted mid-step SHALL abort the step immediately with no step_done pulse.

Verification
REQ-031 Facing down, keycode=0x07, state_num=3 -> direction=3 at once, 4 ticks TURN, positions unchanged, then a WALK step begins.
REQ-032 Facing right, keycode=0x07 held, run_held=0 -> x 320->336 over 16 ticks; charMoveFrame 0,1,2,3; step_done at tick 16.
REQ-033 Same with run_held=1 at start, dropped mid-step -> 8 ticks, charIsRunning=1 throughout, x=336.
REQ-034 atTile=1, spin_direction=1 at step end -> SPIN, y 240->224 in 8 ticks with no key; stops once blocked=1.
REQ-035 x=624 facing right, keycode=0x07 -> no movement, charIsMoving=0; state_num=0 -> keys ignored.
REQ-036 Reset pulsed at tick 5 of a step -> all outputs at reset values asynchronously, no step_done.
